// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, sizing constants and the rotating priority encoder
package sdram_arb_pkg;
  localparam int MAX_PORTS = 8;
  localparam int OWNER_W = $clog2(MAX_PORTS);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  // Returns {found, index} of the first set request bit scanning upward from off, wrapping at n
  function automatic logic [OWNER_W:0] pri_pick(input logic [MAX_PORTS-1:0] req, input logic [OWNER_W-1:0] off, input int n);
    logic [OWNER_W:0] r;
    int j;
    r = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      j = int'(off) + i;
      j = (j >= n) ? j - n : j;
      if (i < n && !r[OWNER_W] && req[j[OWNER_W-1:0]]) r = {1'b1, j[OWNER_W-1:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/sdram_arb_picker.sv
// sdram_arb_picker: combinational winner select; round-robin above port 0 when SDRAM_ARB_ROUND_ROBIN_EN is defined, else fixed priority
module sdram_arb_picker
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [OWNER_W-1:0]   ptr,
  output logic [OWNER_W-1:0]   win,
  output logic                 any
);
  logic [MAX_PORTS-1:0] req_ext;
  logic [OWNER_W:0]     pick;
  assign req_ext = MAX_PORTS'(req);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // The download port always wins; the rest rotate starting at ptr
  assign pick = req_ext[0] ? {1'b1, OWNER_W'(0)} : pri_pick(req_ext & ~MAX_PORTS'(1), ptr, NUM_PORTS);
`else
  // ptr is held at zero by the top, so this is plain lowest-index-wins
  assign pick = pri_pick(req_ext, ptr, NUM_PORTS);
`endif
  assign {any, win} = pick;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: one-outstanding-transaction arbiter sharing the SDRAM controller port; optional SDRAM_ARB_ROUND_ROBIN_EN
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             port_req,
  input  logic [NUM_PORTS-1:0]             port_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_data,
  output logic [NUM_PORTS-1:0]             port_ack,
  output logic [NUM_PORTS-1:0]             port_valid,
  output logic [DATA_WIDTH-1:0]            port_q,
  output logic [ADDR_WIDTH-1:0]            sdram_addr,
  output logic [DATA_WIDTH-1:0]            sdram_data,
  output logic                             sdram_we,
  output logic                             sdram_req,
  input  logic                             sdram_ack,
  input  logic                             sdram_valid,
  input  logic [DATA_WIDTH-1:0]            sdram_q
);
  state_t               state;
  logic [OWNER_W-1:0]   owner, win, ptr;
  logic                 any, rd_done;
  logic [NUM_PORTS-1:0] owner_oh;
  sdram_arb_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req (port_req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Advance the rotation past each new owner, wrapping back to port 1
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (state == IDLE && any) ptr <= (win == OWNER_W'(NUM_PORTS - 1)) ? OWNER_W'(1) : win + 1'b1;
`else
  assign ptr = '0;
`endif
  // Transaction sequencer: latch the winner's request, hold it until accepted, then wait for read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      sdram_req  <= 1'b0;
      sdram_we   <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
    end else begin
      unique case (state)
        IDLE: if (any) begin
          owner      <= win;
          sdram_addr <= ADDR_WIDTH'(port_addr >> (ADDR_WIDTH * int'(win)));
          sdram_data <= DATA_WIDTH'(port_data >> (DATA_WIDTH * int'(win)));
          sdram_we   <= |(port_we & (NUM_PORTS'(1) << win));
          sdram_req  <= 1'b1;
          state      <= REQ;
        end
        REQ: if (sdram_ack) begin
          sdram_req <= 1'b0;
          state     <= (sdram_we || sdram_valid) ? IDLE : WAIT;
        end
        WAIT: if (sdram_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign owner_oh   = NUM_PORTS'(1) << owner;
  assign rd_done    = !sdram_we && sdram_valid && (state == WAIT || (state == REQ && sdram_ack));
  assign port_ack   = (state == REQ && sdram_ack) ? owner_oh : '0;
  assign port_valid = rd_done ? owner_oh : '0;
  assign port_q     = sdram_q;
endmodule
